mux_to_demux_rr: RTL and testbench

- Parametrised N-channel successor to the 4-way mux-to-demux pair.
- Round-robin arbitration picks one valid input channel per cycle and moves its word through one registered stage to a selected output channel, using valid/ready handshakes on every channel.
- Sits between producer and consumer lanes in the OpenHLS datapath wherever several streams share one physical lane.

---
 rtl/mux_to_demux_rr.sv | 136 +++++++++++++
 tb/tb_mux_to_demux_rr.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_to_demux_rr.sv
// N-channel round-robin mux feeding one registered stage that demuxes to a per-word output channel.
// Optional per-output transfer counters are enabled by defining MUX_DEMUX_RR_STATS_EN.
module mux_to_demux_rr #(
  parameter int ID = 1,
  parameter int WIDTH = 2,
  parameter int CHANNELS = 4,
  parameter int ROUTE_MODE = 0,
  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [CHANNELS-1:0]              in_valid,
  output logic [CHANNELS-1:0]              in_ready,
  input  logic [CHANNELS-1:0][WIDTH-1:0]   inp,
  input  logic [CHANNELS-1:0][SEL_W-1:0]   in_dest,
  output logic [CHANNELS-1:0]              out_valid,
  input  logic [CHANNELS-1:0]              out_ready,
  output logic [CHANNELS-1:0][WIDTH-1:0]   outp,
  output logic [SEL_W-1:0]                 grant_sel,
  output logic                             drop_err
`ifdef MUX_DEMUX_RR_STATS_EN
  ,
  output logic [CHANNELS-1:0][15:0]        xfer_count
`endif
);

  localparam logic [SEL_W:0] CH_LIM = (SEL_W + 1)'(CHANNELS);

  if (CHANNELS < 1 || CHANNELS > 64 || ID < 0) begin : g_bad_cfg
    $error("mux_to_demux_rr: illegal configuration");
  end

  logic                 s_vld_reg, s_vld_next;
  logic [WIDTH-1:0]     s_data_reg, s_data_next;
  logic [SEL_W-1:0]     s_dest_reg, s_dest_next;
  logic [SEL_W-1:0]     rr_ptr_reg, rr_ptr_next;
  logic                 drop_err_reg, drop_err_next;

  logic [SEL_W-1:0]     grant;
  logic [SEL_W-1:0]     dest;
  logic                 any_valid;
  logic [CHANNELS-1:0]  ready_hit;
  logic                 stage_ready;
  logic                 load;
  logic                 accept;
  logic                 dest_ok;

  // Scan from rr_ptr upward with wrap; iterating downward lets the nearest candidate win last.
  always_comb begin : arb
    int idx;
    idx = 0;
    grant = '0;
    any_valid = 1'b0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_reg) + k;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (in_valid[SEL_W'(idx)]) begin
        grant = SEL_W'(idx);
        any_valid = 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      assign ready_hit[gi] = out_ready[gi] && (s_dest_reg == SEL_W'(gi));
      assign out_valid[gi] = s_vld_reg && (s_dest_reg == SEL_W'(gi));
      assign outp[gi]      = out_valid[gi] ? s_data_reg : '0;
      assign in_ready[gi]  = accept && (grant == SEL_W'(gi));
    end
  endgenerate

  assign stage_ready = |ready_hit;
  assign load        = !s_vld_reg || stage_ready;
  // Reset gates acceptance so no input sees a handshake while the stage is being cleared.
  assign accept      = !rst && load && any_valid;
  assign dest        = (ROUTE_MODE != 0) ? in_dest[grant] : grant;
  assign dest_ok     = {1'b0, dest} < CH_LIM;
  assign grant_sel   = grant;
  assign drop_err    = drop_err_reg;

  always_comb begin
    s_vld_next    = s_vld_reg;
    s_data_next   = s_data_reg;
    s_dest_next   = s_dest_reg;
    rr_ptr_next   = rr_ptr_reg;
    drop_err_next = 1'b0;
    if (accept) begin
      rr_ptr_next = (grant == SEL_W'(CHANNELS - 1)) ? '0 : grant + SEL_W'(1);
      if (dest_ok) begin
        s_vld_next  = 1'b1;
        s_data_next = inp[grant];
        s_dest_next = dest;
      end else begin
        s_vld_next    = 1'b0;
        drop_err_next = 1'b1;
      end
    end else if (load) begin
      s_vld_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_vld_reg    <= 1'b0;
      s_data_reg   <= '0;
      s_dest_reg   <= '0;
      rr_ptr_reg   <= '0;
      drop_err_reg <= 1'b0;
    end else begin
      s_vld_reg    <= s_vld_next;
      s_data_reg   <= s_data_next;
      s_dest_reg   <= s_dest_next;
      rr_ptr_reg   <= rr_ptr_next;
      drop_err_reg <= drop_err_next;
    end
  end

`ifdef MUX_DEMUX_RR_STATS_EN
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_stats
      logic [15:0] cnt_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg <= '0;
        end else if (out_valid[gi] && out_ready[gi]) begin
          cnt_reg <= cnt_reg + 16'd1;
        end
      end
      assign xfer_count[gi] = cnt_reg;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_mux_to_demux_rr.sv
// Scoreboard bench for mux_to_demux_rr: straight and routed 4-channel instances plus a 3-channel routed one.
module tb_mux_to_demux_rr;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Shared stimulus for the two 4-channel instances.
  logic [3:0]       in_valid;
  logic [3:0][1:0]  inp;
  logic [3:0][1:0]  in_dest;
  logic [3:0]       out_ready;
  logic [3:0]       in_ready_s, in_ready_r, out_valid_s, out_valid_r;
  logic [3:0][1:0]  outp_s, outp_r;
  logic [1:0]       grant_s, grant_r;
  logic             drop_s, drop_r;

  // 3-channel routed instance.
  logic [2:0]       o_in_valid, o_in_ready, o_out_valid, o_out_ready;
  logic [2:0][1:0]  o_inp, o_in_dest, o_outp;
  logic [1:0]       o_grant;
  logic             o_drop;

`ifdef MUX_DEMUX_RR_STATS_EN
  logic [3:0][15:0] xfer_s, xfer_r;
  logic [2:0][15:0] xfer_o;
`endif

  mux_to_demux_rr #(.ID(1), .WIDTH(2), .CHANNELS(4), .ROUTE_MODE(0)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .inp(inp),
    .in_dest(in_dest), .out_valid(out_valid_s), .out_ready(out_ready), .outp(outp_s),
    .grant_sel(grant_s), .drop_err(drop_s)
`ifdef MUX_DEMUX_RR_STATS_EN
    , .xfer_count(xfer_s)
`endif
  );

  mux_to_demux_rr #(.ID(2), .WIDTH(2), .CHANNELS(4), .ROUTE_MODE(1)) dut_r (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_r), .inp(inp),
    .in_dest(in_dest), .out_valid(out_valid_r), .out_ready(out_ready), .outp(outp_r),
    .grant_sel(grant_r), .drop_err(drop_r)
`ifdef MUX_DEMUX_RR_STATS_EN
    , .xfer_count(xfer_r)
`endif
  );

  mux_to_demux_rr #(.ID(3), .WIDTH(2), .CHANNELS(3), .ROUTE_MODE(1)) dut_o (
    .clk(clk), .rst(rst), .in_valid(o_in_valid), .in_ready(o_in_ready), .inp(o_inp),
    .in_dest(o_in_dest), .out_valid(o_out_valid), .out_ready(o_out_ready), .outp(o_outp),
    .grant_sel(o_grant), .drop_err(o_drop)
`ifdef MUX_DEMUX_RR_STATS_EN
    , .xfer_count(xfer_o)
`endif
  );

  // Which 4-channel instance the monitor and direct checks observe.
  logic             use_routed;
  logic [3:0]       obs_in_ready, obs_out_valid;
  logic [3:0][1:0]  obs_outp;
  logic [1:0]       obs_grant;
  always_comb begin
    obs_in_ready  = use_routed ? in_ready_r  : in_ready_s;
    obs_out_valid = use_routed ? out_valid_r : out_valid_s;
    obs_outp      = use_routed ? outp_r      : outp_s;
    obs_grant     = use_routed ? grant_r     : grant_s;
  end

  typedef struct {
    int         chan;
    logic [1:0] data;
  } exp_t;
  exp_t sb[$];

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int chan, input logic [1:0] data);
    exp_t e;
    e.chan = chan;
    e.data = data;
    sb.push_back(e);
  endtask

  // Monitor: every output handshake pops one expected word.
  always @(negedge clk) begin
    if (!rst) begin
      for (int j = 0; j < 4; j++) begin
        if (obs_out_valid[j] && out_ready[j]) begin
          if (sb.size() == 0) begin
            check("sb_unexpected_word", 32'(j), 32'hFFFF_FFFF);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("sb_chan", 32'(j), 32'(e.chan));
            check("sb_data", 32'(obs_outp[j]), 32'(e.data));
          end
        end
      end
    end
  end

  initial begin
    int g;
    int wrap_seq[3];
    rst = 1'b1;
    use_routed = 1'b0;
    in_valid = 4'hF;
    out_ready = 4'hF;
    for (int i = 0; i < 4; i++) begin
      inp[i] = 2'(i);
      in_dest[i] = 2'(i);
    end
    o_in_valid = 3'b000;
    o_out_ready = 3'b111;
    o_inp = '0;
    o_in_dest = '0;

    // Reset held for two cycles with every input valid.
    repeat (2) begin
      @(negedge clk);
      check("rst_in_ready", 32'(obs_in_ready), 32'h0);
      check("rst_out_valid", 32'(obs_out_valid), 32'h0);
      check("rst_outp", 32'(obs_outp), 32'h0);
    end
    step();
    rst = 1'b0;

    // Fairness: all valid, grants rotate 0,1,2,3,...
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("fair_grant", 32'(obs_grant), 32'(c % 4));
      check("fair_in_ready", 32'(obs_in_ready), 32'(1 << (c % 4)));
      push(c % 4, 2'(c % 4));
      step();
    end

    // Skip and wrap: move rr_ptr to 1, then only channels 0 and 3 request.
    in_valid = 4'b0001;
    @(negedge clk);
    check("skip_first_grant", 32'(obs_grant), 32'd0);
    push(0, 2'd0);
    step();
    in_valid = 4'b1001;
    wrap_seq[0] = 3; wrap_seq[1] = 0; wrap_seq[2] = 3;
    for (int c = 0; c < 3; c++) begin
      g = wrap_seq[c];
      @(negedge clk);
      check("skip_grant", 32'(obs_grant), 32'(g));
      check("skip_in_ready", 32'(obs_in_ready), 32'(1 << g));
      push(g, 2'(g));
      step();
    end
    in_valid = 4'b0000;
    step();
    step();

    // Back-pressure on routed output 2.
    use_routed = 1'b1;
    in_dest[0] = 2'd2;
    inp[0] = 2'b11;
    out_ready = 4'b1011;
    in_valid = 4'b0001;
    @(negedge clk);
    check("bp_accept", 32'(obs_in_ready), 32'h1);
    push(2, 2'b11);
    step();
    inp[0] = 2'b01;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_hold_valid", 32'(obs_out_valid), 32'b0100);
      check("bp_hold_data", 32'(obs_outp[2]), 32'd3);
      check("bp_in_ready_low", 32'(obs_in_ready), 32'h0);
      step();
    end
    out_ready = 4'hF;
    @(negedge clk);
    check("bp_release_valid", 32'(obs_out_valid), 32'b0100);
    check("bp_release_data", 32'(obs_outp[2]), 32'd3);
    check("bp_release_grant", 32'(obs_in_ready), 32'h1);
    push(2, 2'b01);
    step();
    in_valid = 4'b0000;
    in_dest[0] = 2'd0;
    inp[0] = 2'd0;
    step();
    step();

    // Out-of-range destination on the 3-channel routed instance.
    o_in_dest[1] = 2'd3;
    o_inp[1] = 2'd1;
    o_in_valid = 3'b010;
    @(negedge clk);
    check("oor_in_ready", 32'(o_in_ready), 32'b010);
    check("oor_grant", 32'(o_grant), 32'd1);
    step();
    o_in_valid = 3'b000;
    @(negedge clk);
    check("oor_drop_pulse", 32'(o_drop), 32'd1);
    check("oor_no_out_valid", 32'(o_out_valid), 32'h0);
    step();
    @(negedge clk);
    check("oor_drop_clear", 32'(o_drop), 32'd0);
    // rr_ptr is now 2; scan 2 -> 0.
    o_in_valid = 3'b001;
    o_in_dest[0] = 2'd2;
    o_inp[0] = 2'd2;
    @(negedge clk);
    check("c3_grant_wrap", 32'(o_grant), 32'd0);
    step();
    o_in_valid = 3'b100;
    o_in_dest[2] = 2'd0;
    o_inp[2] = 2'd1;
    @(negedge clk);
    check("c3_out_valid", 32'(o_out_valid), 32'b100);
    check("c3_outp", 32'(o_outp[2]), 32'd2);
    check("c3_grant_last", 32'(o_grant), 32'd2);
    step();
    // Granting channel 2 must wrap rr_ptr to 0, not to 3.
    o_in_valid = 3'b011;
    @(negedge clk);
    check("c3_ptr_wrap", 32'(o_grant), 32'd0);
    check("c3_routed_valid", 32'(o_out_valid), 32'b001);
    check("c3_routed_data", 32'(o_outp[0]), 32'd1);
    step();
    o_in_valid = 3'b000;
    step();
    step();

`ifdef MUX_DEMUX_RR_STATS_EN
    // Counter wrap: 65537 transfers to channel 1 after a fresh reset.
    use_routed = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    check("stats_reset", 32'(|xfer_s), 32'd0);
    in_valid = 4'b0010;
    for (int n = 0; n < 65537; n++) begin
      @(negedge clk);
      push(1, 2'd1);
      step();
    end
    in_valid = 4'b0000;
    step();
    step();
    @(negedge clk);
    check("stats_ch1_wrap", 32'(xfer_s[1]), 32'd1);
    check("stats_ch0", 32'(xfer_s[0]), 32'd0);
    check("stats_ch2", 32'(xfer_s[2]), 32'd0);
    check("stats_ch3", 32'(xfer_s[3]), 32'd0);
`endif

    @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
